// File: rtl/spi_awaiba_pkg.sv
// Shared constants and state type for the Awaiba-style SPI register responder.
package spi_awaiba_pkg;

  localparam logic [7:0] READ_CMD      = 8'd15;
  localparam logic [4:0] CMD_BITS      = 5'd16;
  localparam logic [4:0] RD_FIRST_RISE = 5'd20;
  localparam logic [4:0] RD_BITS       = 5'd8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    READ  = 2'd2
  } state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for one asynchronous SPI pin, with rise/fall detect
// taken between the second and third stage.
module spi_sync_edge (
  input  logic clk,
  input  logic res,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [2:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[1:0], din};
  end

  always_ff @(posedge clk) begin
    if (res) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign level = sync_q[1];
  assign rise  = sync_q[1] & ~sync_q[2];
  assign fall  = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/spi_awaiba_responder.sv
// SPI responder for the Awaiba sensor register link: decodes 16-bit LSB-first
// {addr,data} frames, commits writes on cs_n rise, answers addr 15 reads on miso.
//
// state | meaning
// IDLE  | waiting for a selected cs_n fall while armed
// SHIFT | collecting the 16 command bits, later rises ignored
// READ  | read decoded, returning the latched byte at rises 20..27
module spi_awaiba_responder
  import spi_awaiba_pkg::*;
#(
  parameter int         REG_COUNT = 16,
  parameter logic       SIDE      = 1'b0,
  parameter logic [7:0] RESET_VAL = 8'h00
) (
  input  logic                   clk,
  input  logic                   res,
  input  logic                   sclk,
  input  logic                   cs_n,
  input  logic                   mosi,
  input  logic                   spi_abn_cdp,
  output logic                   miso,
  output logic [REG_COUNT*8-1:0] regs,
  output logic                   wr_stb,
  output logic [7:0]             wr_addr,
  output logic [7:0]             wr_data,
  output logic                   rd_stb,
  output logic                   frame_err
);

  logic sclk_rise, sclk_fall, sclk_lvl;
  logic cs_lvl, cs_rise, cs_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;
  logic side_lvl, side_rise, side_fall;
  logic unused_edges;

  spi_sync_edge u_sync_sclk (.clk(clk), .res(res), .din(sclk),
                             .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall));
  spi_sync_edge u_sync_cs   (.clk(clk), .res(res), .din(cs_n),
                             .level(cs_lvl), .rise(cs_rise), .fall(cs_fall));
  spi_sync_edge u_sync_mosi (.clk(clk), .res(res), .din(mosi),
                             .level(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall));
  spi_sync_edge u_sync_side (.clk(clk), .res(res), .din(spi_abn_cdp),
                             .level(side_lvl), .rise(side_rise), .fall(side_fall));

  assign unused_edges = ^{sclk_lvl, sclk_fall, mosi_rise, mosi_fall, side_rise, side_fall};

  state_e      state_q, state_d;
  logic [4:0]  rise_q, rise_d;
  logic [15:0] shift_q, shift_d;
  logic        miso_q, miso_d;
  logic        arm_q, arm_d;
  logic [7:0]  rd_byte_q, rd_byte_d;
  logic        wr_stb_q, wr_stb_d;
  logic [7:0]  wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        rd_stb_q, rd_stb_d;
  logic        frame_err_q, frame_err_d;
  logic [7:0]  regs_q [REG_COUNT];
  logic [7:0]  regs_d [REG_COUNT];

  logic [15:0] frame_now;
  logic [7:0]  lookup_byte;

  always_comb begin
    state_d     = state_q;
    rise_d      = rise_q;
    shift_d     = shift_q;
    miso_d      = miso_q;
    arm_d       = arm_q | cs_lvl;
    rd_byte_d   = rd_byte_q;
    wr_stb_d    = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    rd_stb_d    = 1'b0;
    frame_err_d = 1'b0;
    regs_d      = regs_q;

    // Frame including the bit arriving this clock, so the read decode at bit 15 sees it.
    frame_now = shift_q;
    if (rise_q < CMD_BITS) begin
      frame_now[rise_q[3:0]] = mosi_lvl;
    end

    lookup_byte = 8'h00;
    for (int k = 0; k < REG_COUNT; k++) begin
      if (frame_now[7:0] == 8'(k)) lookup_byte = regs_q[k];
    end

    case (state_q)
      IDLE: begin
        miso_d = 1'b0;
        rise_d = 5'd0;
        if (cs_fall && (side_lvl == SIDE) && arm_q) begin
          state_d = SHIFT;
          shift_d = '0;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          state_d = IDLE;
          if (rise_q >= CMD_BITS) begin
            for (int k = 0; k < REG_COUNT; k++) begin
              if ((shift_q[15:8] == 8'(k)) && (shift_q[15:8] != READ_CMD)) begin
                regs_d[k] = shift_q[7:0];
                wr_stb_d  = 1'b1;
                wr_addr_d = shift_q[15:8];
                wr_data_d = shift_q[7:0];
              end
            end
          end else begin
            frame_err_d = 1'b1;
          end
        end else if (sclk_rise) begin
          shift_d = frame_now;
          if (rise_q != 5'd31) rise_d = rise_q + 5'd1;
          if ((rise_q == CMD_BITS - 5'd1) && (frame_now[15:8] == READ_CMD)) begin
            state_d   = READ;
            rd_stb_d  = 1'b1;
            rd_byte_d = lookup_byte;
          end
        end
      end
      READ: begin
        if (cs_rise) begin
          state_d = IDLE;
          miso_d  = 1'b0;
        end else if (sclk_rise) begin
          if (rise_q != 5'd31) rise_d = rise_q + 5'd1;
          if ((rise_q >= RD_FIRST_RISE) && (rise_q < RD_FIRST_RISE + RD_BITS)) begin
            miso_d = rd_byte_q[3'(rise_q - RD_FIRST_RISE)];
          end else begin
            miso_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q     <= IDLE;
      rise_q      <= 5'd0;
      shift_q     <= '0;
      miso_q      <= 1'b0;
      arm_q       <= 1'b0;
      rd_byte_q   <= 8'h00;
      wr_stb_q    <= 1'b0;
      wr_addr_q   <= 8'h00;
      wr_data_q   <= 8'h00;
      rd_stb_q    <= 1'b0;
      frame_err_q <= 1'b0;
      for (int k = 0; k < REG_COUNT; k++) regs_q[k] <= RESET_VAL;
    end else begin
      state_q     <= state_d;
      rise_q      <= rise_d;
      shift_q     <= shift_d;
      miso_q      <= miso_d;
      arm_q       <= arm_d;
      rd_byte_q   <= rd_byte_d;
      wr_stb_q    <= wr_stb_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      rd_stb_q    <= rd_stb_d;
      frame_err_q <= frame_err_d;
      regs_q      <= regs_d;
    end
  end

  for (genvar g = 0; g < REG_COUNT; g++) begin : g_regs
    assign regs[8*g +: 8] = regs_q[g];
  end

  assign miso      = miso_q;
  assign wr_stb    = wr_stb_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign rd_stb    = rd_stb_q;
  assign frame_err = frame_err_q;

endmodule
